// File: rtl/usart_rx_param.sv
// Parametrised asynchronous serial receiver with majority-voted midpoint sampling and valid/ready output.
// Define USART_RX_PARITY_EN to expect a parity bit after the data bits and compute parity_err.
module usart_rx_param #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);
  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int M   = OVERSAMPLE / 2;

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 || DIV < 1) begin : g_bad_params
    $error("usart_rx_param: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef USART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic                   armed_q, armed_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic [SW-1:0]          sub_q, sub_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   fe_acc_q, fe_acc_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
`ifdef USART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  logic rxs, tick, decide, maj, commit, commit_fe;

  // Receive FSM plus prescaler/sub-bit timing; the vote is taken on the M+1 tick.
  always_comb begin
    sync_d    = {sync_q[0], rx};
    state_d   = state_q;
    armed_d   = armed_q;
    pre_d     = pre_q;
    sub_d     = sub_q;
    bit_d     = bit_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    fe_acc_d  = fe_acc_q;
    commit    = 1'b0;
    commit_fe = 1'b0;
`ifdef USART_RX_PARITY_EN
    par_d     = par_q;
`endif
    rxs    = sync_q[1];
    tick   = (pre_q == PW'(DIV - 1));
    decide = tick && (sub_q == SW'(M + 1));
    maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

    if (state_q == IDLE) begin
      pre_d = '0;
      sub_d = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        sub_d = (sub_q == SW'(OVERSAMPLE - 1)) ? '0 : sub_q + 1'b1;
        if (sub_q == SW'(M - 1)) samp_d[0] = rxs;
        if (sub_q == SW'(M))     samp_d[1] = rxs;
      end
    end

    case (state_q)
      IDLE: begin
        if (!armed_q) begin
          armed_d = rxs;
        end else if (!rxs) begin
          state_d  = START;
          bit_d    = '0;
          fe_acc_d = 1'b0;
        end
      end
      START: begin
        if (decide) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef USART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef USART_RX_PARITY_EN
      PARITY: begin
        if (decide) begin
          par_d   = maj ^ (^shift_q) ^ (PARITY_ODD != 0);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (decide) begin
          fe_acc_d = fe_acc_q | ~maj;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            // Commit half a bit early so the next start edge is caught; a framing error disarms IDLE.
            commit    = 1'b1;
            commit_fe = fe_acc_q | ~maj;
            armed_d   = ~(fe_acc_q | ~maj);
            state_d   = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output holding register: a commit into an occupied, unconsumed slot is dropped as an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
`ifdef USART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (commit) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ferr_d  = commit_fe;
`ifdef USART_RX_PARITY_EN
        perr_d  = par_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      pre_q    <= '0;
      sub_q    <= '0;
      bit_q    <= '0;
      samp_q   <= '0;
      shift_q  <= '0;
      fe_acc_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef USART_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      armed_q  <= armed_d;
      pre_q    <= pre_d;
      sub_q    <= sub_d;
      bit_q    <= bit_d;
      samp_q   <= samp_d;
      shift_q  <= shift_d;
      fe_acc_q <= fe_acc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
`ifdef USART_RX_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
`ifdef USART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_usart_rx_param.sv
// Bench for usart_rx_param: an 8N1 receiver and a 7-data/2-stop receiver driven with directed and random frames.
// Expected frames come from a bit-counting model of the line format (parity follows USART_RX_PARITY_EN).
`timescale 1ns/1ps
module tb_usart_rx_param;
  localparam int CLK_F    = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 16;
`ifdef USART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif
  localparam bit ODD = 1'b0;

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, fe_a, pe_a, ovr_a;
  logic       valid_b, fe_b, pe_b, ovr_b;

  int vectors = 0;
  int miscompares = 0;
  int ovr_cnt_a = 0;
  int valid_hi_a = 0;
  frame_t got_a[$];
  frame_t got_b[$];

  always #5 clk = ~clk;

  usart_rx_param #(
    .CLOCK_FREQ(CLK_F), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ovr_a)
  );

  usart_rx_param #(
    .CLOCK_FREQ(CLK_F), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .frame_err(fe_b), .parity_err(pe_b), .overrun_err(ovr_b)
  );

  // Record every frame handed over through the handshake, plus overrun pulses and valid-high cycles.
  always @(negedge clk) begin
    if (valid_a && ready_a) got_a.push_back(frame_t'({1'b0, data_a, fe_a, pe_a}));
    if (valid_b && ready_b) got_b.push_back(frame_t'({2'b00, data_b, fe_b, pe_b}));
    if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
    if (valid_a) valid_hi_a <= valid_hi_a + 1;
  end

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int unit, input logic v);
    if (unit == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t model(input logic [8:0] data, input int nbits, input logic par_bit,
                                   input logic [1:0] stops, input int nstops);
    frame_t f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < nbits; i++) begin
      f.data[i] = data[i];
      ones += int'(data[i]);
    end
    for (int i = 0; i < nstops; i++) if (!stops[i]) f.fe = 1'b1;
    f.pe = HAS_PAR && (((ones + int'(par_bit)) % 2) != (ODD ? 1 : 0));
    return f;
  endfunction

  task automatic send_frame(input int unit, input logic [8:0] data, input int nbits, input logic par_bit,
                            input logic [1:0] stops, input int nstops, input int gap_bits);
    set_rx(unit, 1'b0);
    step(BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      set_rx(unit, data[i]);
      step(BIT_CLKS);
    end
    if (HAS_PAR) begin
      set_rx(unit, par_bit);
      step(BIT_CLKS);
    end
    for (int i = 0; i < nstops; i++) begin
      set_rx(unit, stops[i]);
      step(BIT_CLKS);
    end
    set_rx(unit, 1'b1);
    step(gap_bits * BIT_CLKS);
  endtask

  task automatic check_next(input int unit, input string tag, input frame_t exp);
    frame_t g;
    int waited;
    int avail;
    waited = 0;
    avail = (unit == 0) ? got_a.size() : got_b.size();
    while (avail == 0 && waited < 64) begin
      step(1);
      waited++;
      avail = (unit == 0) ? got_a.size() : got_b.size();
    end
    check($sformatf("%s_present", tag), 32'(avail > 0), 32'd1);
    if (avail > 0) begin
      g = (unit == 0) ? got_a.pop_front() : got_b.pop_front();
      check($sformatf("%s_data", tag), 32'(g.data), 32'(exp.data));
      check($sformatf("%s_frame_err", tag), 32'(g.fe), 32'(exp.fe));
      check($sformatf("%s_parity_err", tag), 32'(g.pe), 32'(exp.pe));
    end
  endtask

  initial begin
    frame_t e;
    logic [8:0] d;
    logic pb;
    logic [1:0] st;
    int gap;
    int snap_ovr;
    int snap_hi;

    // Reset state
    step(3);
    check("reset_valid_a", 32'(valid_a), 32'd0);
    check("reset_data_a", 32'(data_a), 32'd0);
    check("reset_fe_a", 32'(fe_a), 32'd0);
    check("reset_pe_a", 32'(pe_a), 32'd0);
    check("reset_ovr_a", 32'(ovr_a), 32'd0);
    check("reset_valid_b", 32'(valid_b), 32'd0);
    reset_n = 1'b1;
    step(8);

    // 8N1 0xA5 with ready high: a single-cycle valid pulse
    snap_hi = valid_hi_a;
    e = model(9'h0A5, 8, ^8'hA5 ^ ODD, 2'b11, 1);
    send_frame(0, 9'h0A5, 8, ^8'hA5 ^ ODD, 2'b11, 1, 1);
    check_next(0, "a5", e);
    check("a5_valid_cycles", 32'(valid_hi_a - snap_hi), 32'd1);
    check("a5_valid_low", 32'(valid_a), 32'd0);

    // 7 data bits, second stop bit low
    e = model(9'h055, 7, ^7'h55 ^ ODD, 2'b01, 2);
    send_frame(1, 9'h055, 7, ^7'h55 ^ ODD, 2'b01, 2, 1);
    check_next(1, "x55_stop2", e);

    // Parity bit 1 then 0 on 0x03 (only meaningful with the parity build)
    e = model(9'h003, 8, 1'b1, 2'b11, 1);
    send_frame(0, 9'h003, 8, 1'b1, 2'b11, 1, 1);
    check_next(0, "x03_par1", e);
    e = model(9'h003, 8, 1'b0, 2'b11, 1);
    send_frame(0, 9'h003, 8, 1'b0, 2'b11, 1, 1);
    check_next(0, "x03_par0", e);

    // Random frames, sometimes back-to-back, sometimes with a bad stop bit
    for (int i = 0; i < 8; i++) begin
      d   = 9'($urandom_range(0, 255));
      pb  = 1'($urandom_range(0, 1));
      st  = {1'b1, 1'($urandom_range(0, 3) != 0)};
      gap = st[0] ? int'($urandom_range(0, 1)) : 1;
      e = model(d, 8, pb, st, 1);
      send_frame(0, d, 8, pb, st, 1, gap);
      check_next(0, $sformatf("rand_a%0d", i), e);
    end
    for (int i = 0; i < 6; i++) begin
      d   = 9'($urandom_range(0, 127));
      pb  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      gap = (st == 2'b11) ? int'($urandom_range(0, 1)) : 1;
      e = model(d, 7, pb, st, 2);
      send_frame(1, d, 7, pb, st, 2, gap);
      check_next(1, $sformatf("rand_b%0d", i), e);
    end

    // Overrun: hold 0x11 while 0x22 arrives, then consume
    ready_a = 1'b0;
    snap_ovr = ovr_cnt_a;
    send_frame(0, 9'h011, 8, ^8'h11 ^ ODD, 2'b11, 1, 1);
    send_frame(0, 9'h022, 8, ^8'h22 ^ ODD, 2'b11, 1, 1);
    check("ovr_valid_held", 32'(valid_a), 32'd1);
    check("ovr_data_held", 32'(data_a), 32'h11);
    check("ovr_pulses", 32'(ovr_cnt_a - snap_ovr), 32'd1);
    ready_a = 1'b1;
    step(2);
    check_next(0, "ovr_consume", model(9'h011, 8, ^8'h11 ^ ODD, 2'b11, 1));
    check("ovr_valid_cleared", 32'(valid_a), 32'd0);

    // False start: 4-clock glitch produces nothing, then 0x3C is received
    snap_ovr = ovr_cnt_a;
    rx_a = 1'b0;
    step(4);
    rx_a = 1'b1;
    step(3 * BIT_CLKS);
    check("glitch_no_frame", 32'(got_a.size()), 32'd0);
    check("glitch_valid", 32'(valid_a), 32'd0);
    check("glitch_fe", 32'(fe_a), 32'd0);
    check("glitch_pe", 32'(pe_a), 32'd0);
    check("glitch_ovr", 32'(ovr_cnt_a - snap_ovr), 32'd0);
    e = model(9'h03C, 8, ^8'h3C ^ ODD, 2'b11, 1);
    send_frame(0, 9'h03C, 8, ^8'h3C ^ ODD, 2'b11, 1, 1);
    check_next(0, "x3c_after_glitch", e);

    // Reset during data bit 3 of a frame while another frame is held
    ready_a = 1'b0;
    send_frame(0, 9'h05A, 8, ^8'h5A ^ ODD, 2'b11, 1, 1);
    check("pre_reset_held", 32'(data_a), 32'h5A);
    rx_a = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx_a = i[0];
      step(BIT_CLKS);
    end
    rx_a = 1'b1;
    step(BIT_CLKS / 2);
    reset_n = 1'b0;
    #1;
    check("midreset_valid", 32'(valid_a), 32'd0);
    check("midreset_data", 32'(data_a), 32'd0);
    check("midreset_fe", 32'(fe_a), 32'd0);
    check("midreset_pe", 32'(pe_a), 32'd0);
    check("midreset_ovr", 32'(ovr_a), 32'd0);
    step(4);
    reset_n = 1'b1;
    ready_a = 1'b1;
    step(2 * BIT_CLKS);
    check("post_reset_no_frame", 32'(got_a.size()), 32'd0);
    e = model(9'h081, 8, ^8'h81 ^ ODD, 2'b11, 1);
    send_frame(0, 9'h081, 8, ^8'h81 ^ ODD, 2'b11, 1, 1);
    check_next(0, "x81_after_reset", e);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
